// File: rtl/cmp_pkg.sv
// cmp_pkg: shared FSM encoding and default geometry for the sequential magnitude comparator
package cmp_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_BPC   = 1;
endpackage

// File: rtl/cmp_digit.sv
// cmp_digit: combinational unsigned compare of one BPC-bit digit
module cmp_digit #(
    parameter int BPC = cmp_pkg::DEF_BPC
) (
    input  logic [BPC-1:0] x,
    input  logic [BPC-1:0] y,
    output logic           gt,
    output logic           eq
);
    assign gt = x > y;
    assign eq = x == y;
endmodule

// File: rtl/seq_mag_cmp.sv
// seq_mag_cmp: MSB-first digit-serial magnitude comparator with early exit
module seq_mag_cmp
    import cmp_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int BPC   = DEF_BPC
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sgn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic             agreb,
    output logic             aeqb,
    output logic             alesb
);
    localparam int NDIG = WIDTH / BPC;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d, gt_q, gt_d, eq_q, eq_d, lt_q, lt_d;
    logic             dig_gt, dig_eq;
    logic [WIDTH-1:0] sign_msk;
    cmp_digit #(.BPC(BPC)) u_digit (
        .x  (a_q[WIDTH-1 -: BPC]),
        .y  (b_q[WIDTH-1 -: BPC]),
        .gt (dig_gt),
        .eq (dig_eq)
    );
    // flipping both MSBs maps two's-complement order onto unsigned order
    assign sign_msk = {sgn, {(WIDTH-1){1'b0}}};
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        gt_d    = gt_q;
        eq_d    = eq_q;
        lt_d    = lt_q;
        case (state_q)
            IDLE: if (start) begin
                a_d     = a ^ sign_msk;
                b_d     = b ^ sign_msk;
                cnt_d   = '0;
                gt_d    = 1'b0;
                eq_d    = 1'b0;
                lt_d    = 1'b0;
                state_d = BUSY;
            end
            BUSY: if (!dig_eq) begin
                gt_d    = dig_gt;
                lt_d    = !dig_gt;
                done_d  = 1'b1;
                state_d = DONE;
            end else if (cnt_q == CW'(NDIG - 1)) begin
                eq_d    = 1'b1;
                done_d  = 1'b1;
                state_d = DONE;
            end else begin
                a_d   = a_q << BPC;
                b_d   = b_q << BPC;
                cnt_d = cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            gt_q    <= gt_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
        end
    end
    assign ready = state_q == IDLE;
    assign done  = done_q;
    assign agreb = gt_q;
    assign aeqb  = eq_q;
    assign alesb = lt_q;
endmodule

// File: doc/seq_mag_cmp.md
SEQ_MAG_CMP -- requirements
Module: seq_mag_cmp

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width in bits, WIDTH >= 2.
REQ-002 SHALL have parameter BPC, default 1: bits compared per cycle; WIDTH SHALL be an integer multiple of BPC; NDIG = WIDTH/BPC.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request to capture operands; honoured only while ready=1.
REQ-006 SHALL have port sgn  input  1  compare as two's complement when 1, unsigned when 0; sampled with start.
REQ-007 SHALL have port a  input  WIDTH  first operand; sampled with start.
REQ-008 SHALL have port b  input  WIDTH  second operand; sampled with start.
REQ-009 SHALL have port ready  output  1  high only in IDLE.
REQ-010 SHALL have port done  output  1  one-cycle pulse when the result becomes valid.
REQ-011 SHALL have port agreb  output  1  a > b.
REQ-012 SHALL have port aeqb  output  1  a == b.
REQ-013 SHALL have port alesb  output  1  a < b.

Function
REQ-014 SHALL implement an FSM with states IDLE, BUSY, DONE.
REQ-015 IDLE: on start=1, capture a, b into shift registers, clear digit counter, clear all three result outputs, go to BUSY; start=0 stays IDLE.
REQ-016 When sgn=1 at capture, the MSB of both captured operands SHALL be inverted so that the subsequent unsigned compare yields the signed order.
REQ-017 BUSY: each cycle compares the most significant BPC bits of both shift registers (digit i, i=0 most significant).
REQ-018 On the first unequal digit, set agreb or alesb accordingly and go to DONE (early exit); remaining digits are not examined.
REQ-019 On an equal digit with i < NDIG-1, shift both registers left by BPC, increment counter, stay BUSY.
REQ-020 On an equal digit with i = NDIG-1, set aeqb and go to DONE.
REQ-021 DONE: done=1 for exactly one cycle, then IDLE unconditionally.
REQ-022 Latency: with first differing digit i, done SHALL be high exactly i+2 cycles after the start-accept cycle; equal operands give NDIG+1.
REQ-023 Exactly one of agreb/aeqb/alesb SHALL be 1 from the done cycle until the next accepted start; all 0 between accept and done.
REQ-024 start while BUSY or DONE SHALL be ignored; a, b, sgn changes after capture SHALL not affect the result.
REQ-025 Digit counter width SHALL be clog2(NDIG), minimum 1; it SHALL not wrap within an operation.

Reset
REQ-026 reset=1 SHALL force IDLE, ready=1, done=0, agreb=aeqb=alesb=0, counter and shift registers 0, on the next rising edge.
REQ-027 reset asserted in BUSY or DONE SHALL abort the operation; done SHALL not pulse for it.
REQ-028 reset SHALL take priority over start in the same cycle.

Structure
REQ-029 State encodings and the default WIDTH/BPC SHALL live in shared package cmp_pkg.
REQ-030 Per-digit comparison SHALL be a combinational sub-module cmp_digit (BPC-bit inputs, gt/eq outputs) instantiated once.
REQ-031 All outputs SHALL be registered except ready, which SHALL decode the state register only.

Verification (WIDTH=8, BPC=2, NDIG=4)
REQ-032 unsigned a=0xA5 b=0x5A -> agreb=1, done at accept+2.
REQ-033 a=b=0x3C, sgn=0 -> aeqb=1, done at accept+5; same with sgn=1 -> identical result.
REQ-034 a=0x80 b=0x7F: sgn=1 -> alesb=1 at accept+2; sgn=0 -> agreb=1 at accept+2.
REQ-035 a=0x12 b=0x13 unsigned -> alesb=1, done at accept+5 (last-digit difference).
REQ-036 start pulsed during BUSY with different operands -> ignored, original result returned; reset in BUSY -> no done, ready=1 and all results 0 next cycle.
REQ-037 back-to-back: start held high continuously -> new operation accepted in each IDLE cycle after done, results correct per operation.
